sbox_sched: RTL and testbench

//  Byte-serial scheduler sharing NLANES composite-field S-box lanes (GF(2^8)->GF((2^4)^2) map, GF(16^2) inverse, inverse map, affine)

---
 rtl/sbox_sched_pkg.sv | 159 +++++++++++++++
 rtl/sbox_sched_lane.sv | 57 +++++
 rtl/sbox_sched.sv | 172 +++++++++++++++++
 tb/tb_sbox_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_sched_pkg.sv
// Shared definitions for the S-box scheduler.
//  - Job sizes (bytes per round state / key word), FSM states, owner ids.
//  - AES affine constants and the GF(2^8) <-> GF((2^4)^2) field arithmetic
//    used by each S-box lane.
// The isomorphism matrices are derived at elaboration: a root of the AES
// polynomial x^8+x^4+x^3+x+1 is located inside the composite field, its
// powers form the forward map, and the inverse map is solved column by column.
package sbox_sched_pkg;

    localparam int NB_STATE = 16;
    localparam int NB_WORD  = 4;

    localparam logic [7:0] AFF_C     = 8'h63;
    localparam logic [7:0] INV_AFF_C = 8'h05;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    typedef enum logic {
        OWN_ST = 1'b0,
        OWN_KW = 1'b1
    } owner_t;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ AFF_C;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ INV_AFF_C;
    endfunction

    // GF(2^4) with x^4 + x + 1
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // a^-1 = a^14 in GF(16); maps 0 to 0
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a8, a4), a2);
    endfunction

    // Smallest lambda making y^2 + y + lambda irreducible over GF(16)
    function automatic logic [3:0] find_lambda();
        logic [3:0] found;
        logic       done;
        logic       irred;
        found = 4'h0;
        done  = 1'b0;
        for (int l = 1; l < 16; l++) begin
            irred = 1'b1;
            for (int t = 0; t < 16; t++) begin
                if ((gf16_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) irred = 1'b0;
            end
            if (irred && !done) begin
                found = 4'(l);
                done  = 1'b1;
            end
        end
        return found;
    endfunction

    localparam logic [3:0] LAMBDA = find_lambda();

    // Composite element {h,l} = h*y + l, with y^2 = y + LAMBDA
    function automatic logic [7:0] gf256c_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    // Inverse via the norm: delta = h^2*lambda + h*l + l^2, result = {h, h^l} / delta
    function automatic logic [7:0] gf256c_inv(input logic [7:0] a);
        logic [3:0] h, l, d, di;
        h  = a[7:4];
        l  = a[3:0];
        d  = gf16_mul(gf16_mul(h, h), LAMBDA) ^ gf16_mul(h, l) ^ gf16_mul(l, l);
        di = gf16_inv(d);
        return {gf16_mul(h, di), gf16_mul(h ^ l, di)};
    endfunction

    // Linear map: column i (mx[8i+7:8i]) is the image of input bit i
    function automatic logic [7:0] apply_mx(input logic [63:0] mx, input logic [7:0] a);
        logic [7:0] o;
        o = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) o = o ^ mx[8*i +: 8];
        end
        return o;
    endfunction

    function automatic logic [63:0] build_map();
        logic [8:0]  poly;
        logic [7:0]  root, pw, acc;
        logic        found;
        logic [63:0] m;
        poly  = 9'h11B;
        root  = 8'h02;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            pw  = 8'h01;
            acc = 8'h00;
            for (int i = 0; i < 9; i++) begin
                if (poly[i]) acc = acc ^ pw;
                pw = gf256c_mul(pw, 8'(c));
            end
            if (!found && acc == 8'h00) begin
                root  = 8'(c);
                found = 1'b1;
            end
        end
        pw = 8'h01;
        m  = 64'h0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = pw;
            pw = gf256c_mul(pw, root);
        end
        return m;
    endfunction

    function automatic logic [63:0] build_inv_map(input logic [63:0] mx);
        logic [63:0] m;
        logic [7:0]  col;
        m = 64'h0;
        for (int j = 0; j < 8; j++) begin
            col = 8'h00;
            for (int a = 0; a < 256; a++) begin
                if (apply_mx(mx, 8'(a)) == (8'h01 << j)) col = 8'(a);
            end
            m[8*j +: 8] = col;
        end
        return m;
    endfunction

    localparam logic [63:0] MAP_MX  = build_map();
    localparam logic [63:0] IMAP_MX = build_inv_map(MAP_MX);

endpackage

// File: rtl/sbox_sched_lane.sv
// sbox_lane: one composite-field AES S-box (forward or inverse).
//  Path: [inverse affine] -> map -> GF(16^2) inverse -> inverse map -> [affine]
//  Optional macro SBOX_PIPE_EN inserts a register after the GF(16^2) inverse,
//  so the result appears one clock after the input.
// Ports:
//  clk, rst  clock and synchronous active-high reset (pipeline register only)
//  din       input byte
//  inv       1 = inverse S-box, 0 = forward S-box
//  dout      substituted byte
module sbox_lane
    import sbox_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    logic [7:0] pre_map;
    logic [7:0] mapped;
    logic [7:0] inv_c;
    logic [7:0] stage;
    logic       stage_inv;
    logic [7:0] unmapped;

    assign pre_map = inv ? affine_inv(din) : din;
    assign mapped  = apply_mx(MAP_MX, pre_map);
    assign inv_c   = gf256c_inv(mapped);

`ifdef SBOX_PIPE_EN
    logic [7:0] stage_reg;
    logic       inv_pipe_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg    <= 8'h00;
            inv_pipe_reg <= 1'b0;
        end else begin
            stage_reg    <= inv_c;
            inv_pipe_reg <= inv;
        end
    end

    assign stage     = stage_reg;
    assign stage_inv = inv_pipe_reg;
`else
    logic lane_unused;
    assign lane_unused = clk ^ rst;
    assign stage       = inv_c;
    assign stage_inv   = inv;
`endif

    assign unmapped = apply_mx(IMAP_MX, stage);
    assign dout     = stage_inv ? unmapped : affine_fwd(unmapped);

endmodule

// File: rtl/sbox_sched.sv
// sbox_sched: shares NLANES S-box lanes between the round datapath
// (16-byte SubBytes/InvSubBytes) and key expansion (4-byte SubWord).
// A job is captured in a work register, streamed NLANES bytes per cycle
// through the lanes (low bytes first), results shifted in at the top of the
// job window, and returned with a one-cycle done pulse. Key has fixed
// priority; arbitration happens only in IDLE.
// Optional macro SBOX_PIPE_EN: pipelined lanes plus a one-cycle DRAIN state.
// Ports:
//  clk, rst                       clock, synchronous active-high reset
//  st_valid/st_ready/st_inv/st_in round job request (128-bit state)
//  st_done/st_out                 round result pulse and held result
//  kw_valid/kw_ready/kw_in        key SubWord request (32-bit word)
//  kw_done/kw_out                 key result pulse and held result
module sbox_sched
    import sbox_sched_pkg::*;
#(
    parameter int NLANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic         st_inv,
    input  logic [127:0] st_in,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_in,
    output logic         kw_done,
    output logic [31:0]  kw_out
);

    generate
        if (!(NLANES == 1 || NLANES == 2 || NLANES == 4)) begin : g_bad_nlanes
            $error("sbox_sched: NLANES must be 1, 2 or 4");
        end
    endgenerate

    localparam int LW = 8 * NLANES;

    fsm_t           state_reg, state_next;
    owner_t         owner_reg;
    logic           inv_reg;
    logic [127:0]   work_reg;
    logic [3:0]     count_reg;
    logic [127:0]   st_out_reg;
    logic [31:0]    kw_out_reg;
    logic           st_done_reg, kw_done_reg;

    logic [LW-1:0]  lane_out;
    logic [127:0]   work_shift, res_ext, work_run;
    logic           acc_kw, acc_st, finish;

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            sbox_lane u_lane (
                .clk  (clk),
                .rst  (rst),
                .din  (work_reg[8*gi +: 8]),
                .inv  (inv_reg),
                .dout (lane_out[8*gi +: 8])
            );
        end
    endgenerate

    assign acc_kw = (state_reg == IDLE) && kw_valid;
    assign acc_st = (state_reg == IDLE) && !kw_valid && st_valid;

`ifdef SBOX_PIPE_EN
    assign finish = (state_reg == DRAIN);
`else
    assign finish = (state_reg == RUN) && (count_reg == 4'd0);
`endif

    // Consume the low chunk, insert lane results at the top of the job window
    always_comb begin
        work_shift = work_reg >> LW;
        res_ext    = {{(128-LW){1'b0}}, lane_out};
        if (owner_reg == OWN_KW) begin
            work_run = (work_shift & {{96{1'b0}}, {32{1'b1}}}) | (res_ext << (32 - LW));
        end else begin
            work_run = work_shift | (res_ext << (128 - LW));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (acc_kw || acc_st) state_next = RUN;
            end
            RUN: begin
                if (count_reg == 4'd0) begin
`ifdef SBOX_PIPE_EN
                    state_next = DRAIN;
`else
                    state_next = IDLE;
`endif
                end
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: readies only in IDLE and never during reset
    always_comb begin
        st_ready = 1'b0;
        kw_ready = 1'b0;
        if (!rst && state_reg == IDLE) begin
            kw_ready = 1'b1;
            st_ready = !kw_valid;
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg   <= OWN_ST;
            inv_reg     <= 1'b0;
            work_reg    <= 128'h0;
            count_reg   <= 4'd0;
            st_out_reg  <= 128'h0;
            kw_out_reg  <= 32'h0;
            st_done_reg <= 1'b0;
            kw_done_reg <= 1'b0;
        end else begin
            st_done_reg <= finish && (owner_reg == OWN_ST);
            kw_done_reg <= finish && (owner_reg == OWN_KW);
            if (acc_kw) begin
                owner_reg <= OWN_KW;
                inv_reg   <= 1'b0;
                work_reg  <= {96'h0, kw_in};
                count_reg <= 4'(NB_WORD / NLANES - 1);
            end else if (acc_st) begin
                owner_reg <= OWN_ST;
                inv_reg   <= st_inv;
                work_reg  <= st_in;
                count_reg <= 4'(NB_STATE / NLANES - 1);
            end else if (state_reg == RUN || state_reg == DRAIN) begin
                work_reg <= work_run;
                if (state_reg == RUN && count_reg != 4'd0) begin
                    count_reg <= count_reg - 4'd1;
                end
            end
            if (finish) begin
                if (owner_reg == OWN_ST) begin
                    st_out_reg <= work_run;
                end else begin
                    kw_out_reg <= work_run[31:0];
                end
            end
        end
    end

    assign st_done = st_done_reg;
    assign kw_done = kw_done_reg;
    assign st_out  = st_out_reg;
    assign kw_out  = kw_out_reg;

endmodule

// File: tb/tb_sbox_sched.sv
// Testbench for sbox_sched. Reference S-box built from plain GF(2^8)
// arithmetic (brute-force inverse + bitwise affine); inverse table by
// inverting the forward table. Parameter NL selects NLANES.
module tb_sbox_sched #(
    parameter int NL = 1
);

`ifdef SBOX_PIPE_EN
    localparam int XLAT = 1;
`else
    localparam int XLAT = 0;
`endif
    localparam int LAT_ST = 16 / NL + XLAT;
    localparam int LAT_KW = 4 / NL + XLAT;

    logic         clk, rst;
    logic         st_valid, st_ready, st_inv, st_done;
    logic [127:0] st_in, st_out;
    logic         kw_valid, kw_ready, kw_done;
    logic [31:0]  kw_in, kw_out;

    sbox_sched #(.NLANES(NL)) dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_inv   (st_inv),
        .st_in    (st_in),
        .st_done  (st_done),
        .st_out   (st_out),
        .kw_valid (kw_valid),
        .kw_ready (kw_ready),
        .kw_in    (kw_in),
        .kw_done  (kw_done),
        .kw_out   (kw_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] exp_st_out;
    logic [31:0]  exp_kw_out;

    typedef struct {
        logic         is_kw;
        logic         inv;
        logic [127:0] din;
        logic [127:0] req;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] v, s, c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            v = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) v = 8'(b);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
            end
            sb[a] = s;
        end
        for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);
    endtask

    function automatic logic [127:0] model(input logic is_kw, input logic inv, input logic [127:0] din);
        logic [127:0] r;
        int n;
        r = 128'h0;
        n = is_kw ? 4 : 16;
        for (int k = 0; k < n; k++) begin
            r[8*k +: 8] = inv ? isb[din[8*k +: 8]] : sb[din[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic wait_done(input logic is_kw, output int cyc, output logic stray);
        cyc   = 0;
        stray = 1'b0;
        while (cyc <= 40 && !(is_kw ? kw_done : st_done)) begin
            if (is_kw ? st_done : kw_done) stray = 1'b1;
            tick();
            cyc++;
        end
    endtask

    task automatic run_job(input string name, input logic is_kw, input logic inv,
                           input logic [127:0] din, input logic [127:0] req);
        int   cyc;
        logic stray;
        if (is_kw) begin
            kw_valid = 1'b1;
            kw_in    = din[31:0];
        end else begin
            st_valid = 1'b1;
            st_in    = din;
            st_inv   = inv;
        end
        #1;
        check({name, " ready"}, is_kw ? kw_ready : st_ready, 1'b1);
        tick();
        kw_valid = 1'b0;
        st_valid = 1'b0;
        kw_in    = $urandom;
        st_in    = {$urandom, $urandom, $urandom, $urandom};
        st_inv   = 1'($urandom);
        wait_done(is_kw, cyc, stray);
        check({name, " latency"}, 128'(cyc), is_kw ? 128'(LAT_KW) : 128'(LAT_ST));
        if (is_kw) exp_kw_out = req[31:0];
        else       exp_st_out = req;
        check({name, " st_out"}, st_out, exp_st_out);
        check({name, " kw_out"}, 128'(kw_out), 128'(exp_kw_out));
        check({name, " other_done"}, stray, 1'b0);
        tick();
        check({name, " done_pulse"}, is_kw ? kw_done : st_done, 1'b0);
        $display("job %s kw=%0d inv=%0d din=%h out=%h lat=%0d", name, is_kw, inv, din,
                 is_kw ? 128'(kw_out) : st_out, cyc);
    endtask

    initial begin
        int   cyc, pre;
        logic stray, bad;
        logic is_kw, inv;
        logic [127:0] din;

        build_tables();
        vt[0] = '{1'b0, 1'b0, 128'h0, {16{8'h63}}};
        vt[1] = '{1'b0, 1'b0, 128'h00102030405060708090a0b0c0d0e0f0,
                  128'h63cab7040953d051cd60e0e7ba70e18c};
        vt[2] = '{1'b0, 1'b1, 128'h63cab7040953d051cd60e0e7ba70e18c,
                  128'h00102030405060708090a0b0c0d0e0f0};
        vt[3] = '{1'b1, 1'b0, 128'h53535353, 128'hEDEDEDED};
        vt[4] = '{1'b1, 1'b0, 128'h0, 128'h63636363};
        vt[5] = '{1'b0, 1'b1, {16{8'h63}}, 128'h0};

        rst = 1'b1; st_valid = 1'b1; kw_valid = 1'b1; st_inv = 1'b0;
        st_in = 128'h0; kw_in = 32'h0;
        exp_st_out = 128'h0; exp_kw_out = 32'h0;
        tick(); tick();
        check("rst st_ready", st_ready, 1'b0);
        check("rst kw_ready", kw_ready, 1'b0);
        check("rst st_done", st_done, 1'b0);
        check("rst kw_done", kw_done, 1'b0);
        check("rst st_out", st_out, 128'h0);
        check("rst kw_out", 128'(kw_out), 128'h0);
        rst = 1'b0; st_valid = 1'b0; kw_valid = 1'b0;
        #1;
        check("idle st_ready", st_ready, 1'b1);
        check("idle kw_ready", kw_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_job($sformatf("vec%0d", i), vt[i].is_kw, vt[i].inv, vt[i].din, vt[i].req);
        end

        st_valid = 1'b1; st_inv = 1'b0; st_in = 128'h00102030405060708090a0b0c0d0e0f0;
        kw_valid = 1'b1; kw_in = 32'h53535353;
        #1;
        check("arb st_ready", st_ready, 1'b0);
        check("arb kw_ready", kw_ready, 1'b1);
        tick();
        kw_valid = 1'b0; kw_in = $urandom;
        cyc = 0; bad = 1'b0;
        while (cyc <= 40 && !kw_done) begin
            if (st_ready) bad = 1'b1;
            tick();
            cyc++;
        end
        check("arb kw latency", 128'(cyc), 128'(LAT_KW));
        check("arb kw_out", 128'(kw_out), 128'hEDEDEDED);
        check("arb stall", bad, 1'b0);
        check("arb st_ready at kw_done", st_ready, 1'b1);
        tick();
        st_valid = 1'b0; st_in = 128'h0;
        wait_done(1'b0, cyc, stray);
        check("arb st latency", 128'(cyc), 128'(LAT_ST));
        check("arb st_out", st_out, 128'h63cab7040953d051cd60e0e7ba70e18c);
        check("arb kw_out kept", 128'(kw_out), 128'hEDEDEDED);
        $display("job arb kw_out=%h st_out=%h", kw_out, st_out);
        exp_st_out = 128'h63cab7040953d051cd60e0e7ba70e18c;
        exp_kw_out = 32'hEDEDEDED;
        tick();

        for (int i = 0; i < 24; i++) begin
            is_kw = 1'($urandom);
            inv   = is_kw ? 1'b0 : 1'($urandom);
            din   = {$urandom, $urandom, $urandom, $urandom};
            if (is_kw) din = {96'h0, din[31:0]};
            run_job($sformatf("rnd%0d", i), is_kw, inv, din, model(is_kw, inv, din));
        end

        pre = (LAT_ST > 6) ? 4 : 1;
        st_valid = 1'b1; st_inv = 1'b0; st_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        st_valid = 1'b0;
        repeat (pre) tick();
        rst = 1'b1;
        #1;
        check("midrst st_ready", st_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst st_out", st_out, 128'h0);
        check("midrst kw_out", 128'(kw_out), 128'h0);
        check("midrst st_ready", st_ready, 1'b1);
        stray = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (st_done || kw_done) stray = 1'b1;
            tick();
        end
        check("midrst no done", stray, 1'b0);
        $display("job midrst st_out=%h kw_out=%h", st_out, kw_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
